gpio_cfg_serial_loader: RTL and testbench



---
 rtl/gpio_cfg_pkg.sv | 41 ++++
 rtl/gpio_cfg_serial_loader_if.sv | 45 ++++
 rtl/gpio_serial_bit_timer.sv | 44 ++++
 rtl/gpio_cfg_serial_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_gpio_cfg_serial_loader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO configuration serial loader: FSM state
// encoding, the default per-pad word width, the bit layout of one pad
// configuration word, and small elaboration-time helpers.
package gpio_cfg_pkg;

    // Default width of one pad configuration word.
    localparam int GPIO_CFG_BITS = 13;

    // Loader sequence states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        SHIFT = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } gpio_cfg_state_e;

    // Bit positions inside one pad configuration word.
    localparam int CFG_MGMT_EN     = 0;
    localparam int CFG_OEB         = 1;
    localparam int CFG_HOLDOVER    = 2;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_ANALOG_EN   = 5;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 7;
    localparam int CFG_SLOW        = 8;
    localparam int CFG_VTRIP       = 9;
    localparam int CFG_DM_LSB      = 10;
    localparam int CFG_DM_WIDTH    = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter or index that must hold values 0..n-1 (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_cfg_serial_loader_if.sv
// Request/status and pad-chain signals of the GPIO configuration loader.
// The master side (housekeeping) issues start and supplies the flat config
// vector; the slave side (the loader) drives status and the serial chains.
interface gpio_cfg_serial_loader_if
    import gpio_cfg_pkg::*;
#(
    parameter int TOTAL_PADS = 38,
    parameter int CFG_BITS   = GPIO_CFG_BITS
);

    logic                           start;
    logic [TOTAL_PADS*CFG_BITS-1:0] cfg_flat;
    logic                           busy;
    logic                           done;
    logic                           serial_clock;
    logic                           serial_load;
    logic                           serial_resetn;
    logic                           serial_data_1;
    logic                           serial_data_2;

    modport master (
        output start,
        output cfg_flat,
        input  busy,
        input  done,
        input  serial_clock,
        input  serial_load,
        input  serial_resetn,
        input  serial_data_1,
        input  serial_data_2
    );

    modport slave (
        input  start,
        input  cfg_flat,
        output busy,
        output done,
        output serial_clock,
        output serial_load,
        output serial_resetn,
        output serial_data_1,
        output serial_data_2
    );

endinterface

// File: rtl/gpio_serial_bit_timer.sv
// Phase timer for the serial pad chains. While run is high it divides the
// system clock into bit periods of 2*CLK_DIV cycles: a low phase followed by
// a high phase, CLK_DIV cycles each. phase_end marks the last cycle of either
// phase, bit_end the last cycle of the high phase. Dropping run rewinds it so
// the next period always starts at the beginning of a low phase.
module gpio_serial_bit_timer
    import gpio_cfg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic run,
    output logic phase_end,
    output logic high_phase,
    output logic bit_end
);

    localparam int             CW         = idx_width(CLK_DIV);
    localparam logic [CW-1:0]  PHASE_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] phase_cnt;
    logic          half;

    // Count cycles within a phase and toggle the phase at its last cycle.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (wb_rst_i || !run) begin
            phase_cnt <= '0;
            half      <= 1'b0;
        end else if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            half      <= ~half;
        end else begin
            phase_cnt <= phase_cnt + CW'(1);
        end
    end

    assign phase_end  = run && (phase_cnt == PHASE_LAST);
    assign high_phase = half;
    assign bit_end    = phase_end && half;

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// GPIO pad configuration serial loader.
// On a start request it resets both pad control chains, shifts LMAX*CFG_BITS
// bits into each (shorter chain padded with leading zero words), pulses the
// parallel-load strobe and reports done. Chain 1 receives pads AREA1PADS-1
// down to 0, chain 2 pads AREA1PADS up to TOTAL_PADS-1, each word MSB first.
// Optional build macro GPIO_CFG_SNAPSHOT_EN: capture cfg_flat into a shadow
// register when a transfer is accepted; otherwise cfg_flat is read live at
// every bit boundary and must be held stable while busy.
module gpio_cfg_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int TOTAL_PADS = 38,
    parameter int AREA1PADS  = 19,
    parameter int CFG_BITS   = GPIO_CFG_BITS,
    parameter int CLK_DIV    = 2
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    gpio_cfg_serial_loader_if.slave bus
);

    localparam int L1    = AREA1PADS;
    localparam int L2    = TOTAL_PADS - AREA1PADS;
    localparam int LMAX  = max_int(L1, L2);
    localparam int CFG_W = TOTAL_PADS * CFG_BITS;
    // Leading zero words on each chain so both finish on the same bit.
    localparam int Z1    = LMAX - L1;
    localparam int Z2    = LMAX - L2;
    localparam int WW    = idx_width(LMAX);
    localparam int BW    = idx_width(CFG_BITS);
    localparam int IW    = idx_width(CFG_W);

    localparam logic [WW-1:0] WORD_LAST = WW'(LMAX - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_RST   = RST;
    localparam logic [2:0] S_SHIFT = SHIFT;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]    state;
    logic [WW-1:0] word_idx;   // word slot currently on the chains (0 = first shifted)
    logic [BW-1:0] bit_idx;    // bit within that word, counts down from MSB
    logic [WW-1:0] word_nxt;
    logic [BW-1:0] bit_nxt;
    logic          last_bit;
    logic          d1_nxt;
    logic          d2_nxt;
    logic [IW-1:0] idx1;
    logic [IW-1:0] idx2;
    int            pad1;
    int            pad2;

    logic          busy_q;
    logic          done_q;
    logic          sclk_q;
    logic          sload_q;
    logic          sresetn_q;
    logic          sdata1_q;
    logic          sdata2_q;

    logic          run;
    logic          phase_end;
    logic          high_phase;
    logic          bit_end;

    logic [CFG_W-1:0] cfg_src;

`ifdef GPIO_CFG_SNAPSHOT_EN
    logic [CFG_W-1:0] cfg_shadow;

    // Freeze the configuration on the cycle a transfer is accepted.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: the shadow is pure data, only read after a start has loaded
        // it, so it carries no reset.
        if (state == S_IDLE && bus.start) begin
            cfg_shadow <= bus.cfg_flat;
        end
    end

    assign cfg_src = cfg_shadow;
`else
    assign cfg_src = bus.cfg_flat;
`endif

    assign run = (state == S_RST) || (state == S_SHIFT) || (state == S_LOAD);

    gpio_serial_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .run        (run),
        .phase_end  (phase_end),
        .high_phase (high_phase),
        .bit_end    (bit_end)
    );

    assign last_bit = (word_idx == WORD_LAST) && (bit_idx == '0);

    // Position and chain data of the bit that starts at the next bit boundary.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value held and no latch is inferred.
        word_nxt = word_idx;
        bit_nxt  = bit_idx;
        pad1     = 0;
        pad2     = 0;
        idx1     = '0;
        idx2     = '0;
        d1_nxt   = 1'b0;
        d2_nxt   = 1'b0;

        if (state == S_RST) begin
            word_nxt = '0;
            bit_nxt  = BIT_LAST;
        end else if (bit_idx == '0) begin
            word_nxt = word_idx + WW'(1);
            bit_nxt  = BIT_LAST;
        end else begin
            bit_nxt  = bit_idx - BW'(1);
        end

        // Chain 1 walks pads downward, chain 2 upward, after their zero words.
        pad1 = LMAX - 1 - int'(word_nxt);
        pad2 = AREA1PADS + int'(word_nxt) - Z2;

        if (int'(word_nxt) >= Z1) begin
            idx1   = IW'(pad1 * CFG_BITS + int'(bit_nxt));
            d1_nxt = cfg_src[idx1];
        end
        if (int'(word_nxt) >= Z2) begin
            idx2   = IW'(pad2 * CFG_BITS + int'(bit_nxt));
            d2_nxt = cfg_src[idx2];
        end
    end

    // Sequence FSM; all chain outputs are registered alongside the state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            bit_idx   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sload_q   <= 1'b0;
            sresetn_q <= 1'b0;
            sdata1_q  <= 1'b0;
            sdata2_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_RST;
                        busy_q    <= 1'b1;
                        sresetn_q <= 1'b0;
                    end else begin
                        sresetn_q <= 1'b1;
                    end
                end

                S_RST: begin
                    if (bit_end) begin
                        state     <= S_SHIFT;
                        sresetn_q <= 1'b1;
                        word_idx  <= word_nxt;
                        bit_idx   <= bit_nxt;
                        sdata1_q  <= d1_nxt;
                        sdata2_q  <= d2_nxt;
                    end
                end

                S_SHIFT: begin
                    if (bit_end) begin
                        sclk_q <= 1'b0;
                        if (last_bit) begin
                            state    <= S_LOAD;
                            sload_q  <= 1'b1;
                            sdata1_q <= 1'b0;
                            sdata2_q <= 1'b0;
                        end else begin
                            word_idx <= word_nxt;
                            bit_idx  <= bit_nxt;
                            sdata1_q <= d1_nxt;
                            sdata2_q <= d2_nxt;
                        end
                    end else if (phase_end && !high_phase) begin
                        // End of the low phase: chains sample on this rising edge.
                        sclk_q <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (bit_end) begin
                        state   <= S_DONE;
                        sload_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.serial_clock  = sclk_q;
    assign bus.serial_load   = sload_q;
    assign bus.serial_resetn = sresetn_q;
    assign bus.serial_data_1 = sdata1_q;
    assign bus.serial_data_2 = sdata2_q;

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Self-checking bench for gpio_cfg_serial_loader. Two instances: the default
// 38-pad configuration and a small 5-pad one with CLK_DIV=1. Expected chain
// bits are pushed to per-chain queues when a transfer is started and popped
// at every rising serial_clock edge. All observation happens at the falling
// clock edge; inputs change right after it.
module tb_gpio_cfg_serial_loader;

    localparam int TP_A = 38, A1_A = 19, CB_A = 13, CD_A = 2;
    localparam int NB_A = 19 * 13;
    localparam int TP_B = 5,  A1_B = 2,  CB_B = 4,  CD_B = 1;
    localparam int NB_B = 3 * 4;
    localparam int BUSY_A = 2*CD_A + NB_A*2*CD_A + 2*CD_A + 1;
    localparam int BUSY_B = 2*CD_B + NB_B*2*CD_B + 2*CD_B + 1;

    logic clk = 1'b0;
    logic rst_a, rst_b;

    always #5 clk = ~clk;

    gpio_cfg_serial_loader_if #(.TOTAL_PADS(TP_A), .CFG_BITS(CB_A)) bus_a ();
    gpio_cfg_serial_loader_if #(.TOTAL_PADS(TP_B), .CFG_BITS(CB_B)) bus_b ();

    gpio_cfg_serial_loader #(
        .TOTAL_PADS(TP_A), .AREA1PADS(A1_A), .CFG_BITS(CB_A), .CLK_DIV(CD_A)
    ) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst_a),
        .bus      (bus_a)
    );

    gpio_cfg_serial_loader #(
        .TOTAL_PADS(TP_B), .AREA1PADS(A1_B), .CFG_BITS(CB_B), .CLK_DIV(CD_B)
    ) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst_b),
        .bus      (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic q1_a[$], q2_a[$], q1_b[$], q2_b[$];

    // Statistics gathered by tick()
    int rises_a, busy_a, done_a, overlap_a, load_run_a, last_load_a, rstn_low_a;
    int rises_b, busy_b, done_b;
    logic psc_a, psc_b;
    logic [12:0] first_w1_a, last_w1_a;
    logic [11:0] rx1_b, rx2_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected stream bit i of a chain, straight from the chain ordering rule.
    function automatic logic exp_bit(input logic [511:0] cfg, input int tp, input int a1,
                                     input int cb, input int chain, input int i);
        int l1, l2, lmax, z, j, pad, bitn;
        l1   = a1;
        l2   = tp - a1;
        lmax = (l1 > l2) ? l1 : l2;
        z    = (lmax - ((chain == 1) ? l1 : l2)) * cb;
        if (i < z) return 1'b0;
        j    = i - z;
        bitn = cb - 1 - (j % cb);
        pad  = (chain == 1) ? (l1 - 1 - j / cb) : (a1 + j / cb);
        return cfg[pad*cb + bitn];
    endfunction

    task automatic push_a(input int from);
        logic [511:0] w;
        w = 512'(bus_a.cfg_flat);
        for (int i = from; i < NB_A; i++) begin
            q1_a.push_back(exp_bit(w, TP_A, A1_A, CB_A, 1, i));
            q2_a.push_back(exp_bit(w, TP_A, A1_A, CB_A, 2, i));
        end
    endtask

    task automatic push_b();
        logic [511:0] w;
        w = 512'(bus_b.cfg_flat);
        for (int i = 0; i < NB_B; i++) begin
            q1_b.push_back(exp_bit(w, TP_B, A1_B, CB_B, 1, i));
            q2_b.push_back(exp_bit(w, TP_B, A1_B, CB_B, 2, i));
        end
    endtask

    task automatic clear_stats();
        rises_a = 0; busy_a = 0; done_a = 0; overlap_a = 0;
        load_run_a = 0; last_load_a = 0; rstn_low_a = 0;
        rises_b = 0; busy_b = 0; done_b = 0;
        first_w1_a = '0; last_w1_a = '0; rx1_b = '0; rx2_b = '0;
    endtask

    // Advance one cycle and observe both instances at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (bus_a.serial_clock && !psc_a) begin
            rises_a++;
            if (q1_a.size() == 0 || q2_a.size() == 0) begin
                check("a_unexpected_edge", 32'(rises_a), 32'(NB_A));
            end else begin
                check("a_chain1_bit", 32'(bus_a.serial_data_1), 32'(q1_a.pop_front()));
                check("a_chain2_bit", 32'(bus_a.serial_data_2), 32'(q2_a.pop_front()));
            end
            last_w1_a = {last_w1_a[11:0], bus_a.serial_data_1};
            if (rises_a <= 13) first_w1_a = {first_w1_a[11:0], bus_a.serial_data_1};
        end
        if (bus_a.serial_clock && bus_a.serial_load) overlap_a++;
        if (bus_a.busy) busy_a++;
        if (bus_a.done) done_a++;
        if (bus_a.busy && !bus_a.serial_resetn && rises_a == 0) rstn_low_a++;
        if (bus_a.serial_load) begin
            load_run_a++;
        end else if (load_run_a != 0) begin
            last_load_a = load_run_a;
            load_run_a  = 0;
        end
        psc_a = bus_a.serial_clock;

        if (bus_b.serial_clock && !psc_b) begin
            rises_b++;
            if (q1_b.size() == 0 || q2_b.size() == 0) begin
                check("b_unexpected_edge", 32'(rises_b), 32'(NB_B));
            end else begin
                check("b_chain1_bit", 32'(bus_b.serial_data_1), 32'(q1_b.pop_front()));
                check("b_chain2_bit", 32'(bus_b.serial_data_2), 32'(q2_b.pop_front()));
            end
            rx1_b = {rx1_b[10:0], bus_b.serial_data_1};
            rx2_b = {rx2_b[10:0], bus_b.serial_data_2};
        end
        if (bus_b.busy) busy_b++;
        if (bus_b.done) done_b++;
        psc_b = bus_b.serial_clock;
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    // Run until busy drops, optionally re-pulsing start at two cycle offsets.
    task automatic wait_a(input int p1, input int p2);
        int n;
        n = 0;
        while (bus_a.busy && n < 3000) begin
            bus_a.start = (n == p1) || (n == p2);
            tick();
            n++;
        end
        bus_a.start = 1'b0;
        check("a_busy_drop_in_budget", 32'(n < 3000), 32'd1);
    endtask

    task automatic check_full_a(input string tag);
        check({tag, "_busy_cycles"}, 32'(busy_a), 32'(BUSY_A));
        check({tag, "_clock_edges"}, 32'(rises_a), 32'(NB_A));
        check({tag, "_done_pulses"}, 32'(done_a), 32'd1);
        check({tag, "_queue_left"}, 32'(q1_a.size() + q2_a.size()), 32'd0);
    endtask

    function automatic logic [6:0] outs_a();
        return {bus_a.busy, bus_a.done, bus_a.serial_clock, bus_a.serial_load,
                bus_a.serial_resetn, bus_a.serial_data_1, bus_a.serial_data_2};
    endfunction

    function automatic logic [6:0] outs_b();
        return {bus_b.busy, bus_b.done, bus_b.serial_clock, bus_b.serial_load,
                bus_b.serial_resetn, bus_b.serial_data_1, bus_b.serial_data_2};
    endfunction

    initial begin
        logic [TP_A*CB_A-1:0] cfg_saved;
        int n;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        for (int p = 0; p < TP_A; p++) bus_a.cfg_flat[p*CB_A +: CB_A] = 13'(p);
        bus_b.cfg_flat = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
        psc_a = 1'b0;
        psc_b = 1'b0;
        clear_stats();

        // Reset state
        repeat (3) tick();
        check("a_reset_outputs", 32'(outs_a()), 32'd0);
        check("b_reset_outputs", 32'(outs_b()), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        check("a_resetn_after_release", 32'(bus_a.serial_resetn), 32'd1);
        check("b_resetn_after_release", 32'(bus_b.serial_resetn), 32'd1);
        check("a_idle_busy", 32'(bus_a.busy), 32'd0);
        clear_stats();

        // Full default transfer, pad n carries value n
        push_a(0);
        start_a();
        wait_a(-1, -1);
        check_full_a("t1");
        check("t1_first_word_chain1", 32'(first_w1_a), 32'h12);
        check("t1_last_word_chain1", 32'(last_w1_a), 32'h0);
        check("t1_load_cycles", 32'(last_load_a), 32'(2*CD_A));
        check("t1_load_clock_overlap", 32'(overlap_a), 32'd0);
        check("t1_resetn_low_cycles", 32'(rstn_low_a), 32'(2*CD_A));
        tick();
        clear_stats();

        // Small instance: uneven chains, CLK_DIV=1
        push_b();
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        n = 0;
        while (bus_b.busy && n < 200) begin
            tick();
            n++;
        end
        check("b_busy_drop_in_budget", 32'(n < 200), 32'd1);
        check("b_busy_cycles", 32'(busy_b), 32'(BUSY_B));
        check("b_clock_edges", 32'(rises_b), 32'(NB_B));
        check("b_done_pulses", 32'(done_b), 32'd1);
        check("b_chain1_stream", 32'(rx1_b), 32'b0000_1011_1010);
        check("b_chain2_stream", 32'(rx2_b), 32'b1100_1101_1110);
        tick();
        clear_stats();

        // Start re-pulsed during a transfer is ignored
        push_a(0);
        start_a();
        wait_a(10, 500);
        check_full_a("t3");
        tick();
        clear_stats();

        // Reset in the middle of SHIFT abandons the transfer
        push_a(0);
        start_a();
        n = 0;
        while (rises_a < 100 && n < 3000) begin
            tick();
            n++;
        end
        check("t4_reach_bit100", 32'(rises_a), 32'd100);
        rst_a = 1'b1;
        tick();
        check("t4_outputs_after_reset", 32'(outs_a()), 32'd0);
        check("t4_no_done", 32'(done_a), 32'd0);
        rst_a = 1'b0;
        tick();
        check("t4_idle_after_release", 32'({bus_a.busy, bus_a.serial_resetn}), 32'b01);
        q1_a.delete();
        q2_a.delete();
        tick();
        check("t4_still_idle", 32'(bus_a.busy), 32'd0);
        clear_stats();
        push_a(0);
        start_a();
        wait_a(-1, -1);
        check_full_a("t4_restart");
        tick();
        clear_stats();

        // cfg_flat changed to all ones after 50 bits have been clocked
        cfg_saved = bus_a.cfg_flat;
        push_a(0);
        start_a();
        n = 0;
        while (rises_a < 50 && n < 3000) begin
            tick();
            n++;
        end
        check("t6_reach_bit50", 32'(rises_a), 32'd50);
        bus_a.cfg_flat = '1;
`ifndef GPIO_CFG_SNAPSHOT_EN
        // Live sampling: bits from index 50 onward come from the new value.
        q1_a.delete();
        q2_a.delete();
        push_a(50);
`endif
        wait_a(-1, -1);
        check_full_a("t6");
        bus_a.cfg_flat = cfg_saved;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
